// File: rtl/seg_ctrl_pkg.sv
// Shared types and segment encoding for the seven-segment display arbiter.
package seg_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } seg_arb_state_t;

    localparam int unsigned NIB_W      = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned FRAME_W    = NIB_W * NUM_DIGITS;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    // Active-high segments, bit0=a .. bit6=g, indexed by hex nibble.
    localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [NIB_W-1:0] nibble);
        return HEX_SEG[nibble];
    endfunction

endpackage

// File: rtl/hex7seg_decoder.sv
// Combinational hex nibble to active-high seven-segment pattern.
module hex7seg_decoder
    import seg_ctrl_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg_c
);

    assign o_seg_c = hex_to_seg(i_nibble);

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter granting two requesters ownership of a four-digit display,
// latching the decoded frame and holding ownership for a minimum dwell time.
module seg_display_arbiter
    import seg_ctrl_pkg::*;
#(
    parameter int unsigned HOLD_W      = 20,
    parameter int unsigned HOLD_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic [15:0] a_data,
    input  logic [3:0]  a_blank,
    output logic        a_ack,
    input  logic        b_req,
    input  logic [15:0] b_data,
    input  logic [3:0]  b_blank,
    output logic        b_ack,
    output logic [6:0]  digit0_segments,
    output logic [6:0]  digit1_segments,
    output logic [6:0]  digit2_segments,
    output logic [6:0]  digit3_segments,
    output logic        owner,
    output logic        busy
);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    seg_arb_state_t     r_state;
    logic               r_win;
    logic               r_last_grant;
    logic               r_owner;
    logic               r_a_ack;
    logic               r_b_ack;
    logic               r_busy;
    logic [HOLD_W-1:0]  r_cnt;
    logic [SEG_W-1:0]   r_seg [NUM_DIGITS];

    logic [FRAME_W-1:0]    w_win_data;
    logic [NUM_DIGITS-1:0] w_win_blank;
    logic [SEG_W-1:0]      w_seg [NUM_DIGITS];
    logic                  w_idle_win;
    logic                  w_owner_req;

    assign w_win_data  = (r_win == REQ_B) ? b_data  : a_data;
    assign w_win_blank = (r_win == REQ_B) ? b_blank : a_blank;
    // On a tie the requester not granted last wins.
    assign w_idle_win  = (a_req && b_req) ? ~r_last_grant : b_req;
    assign w_owner_req = (r_owner == REQ_B) ? b_req : a_req;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dec
        hex7seg_decoder u_dec (
            .i_nibble (w_win_data[gi*NIB_W +: NIB_W]),
            .o_seg_c  (w_seg[gi])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_win        <= REQ_A;
            r_last_grant <= REQ_B;
            r_owner      <= REQ_A;
            r_a_ack      <= 1'b0;
            r_b_ack      <= 1'b0;
            r_busy       <= 1'b0;
            r_cnt        <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_seg[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (a_req || b_req) begin
                        r_state <= GRANT;
                        r_win   <= w_idle_win;
                        r_a_ack <= (w_idle_win == REQ_A);
                        r_b_ack <= (w_idle_win == REQ_B);
                        r_busy  <= 1'b1;
                    end
                end
                GRANT: begin
                    r_a_ack      <= 1'b0;
                    r_b_ack      <= 1'b0;
                    r_owner      <= r_win;
                    r_last_grant <= r_win;
                    r_cnt        <= HOLD_LOAD;
                    r_state      <= HOLD;
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        r_seg[i] <= w_win_blank[i] ? '0 : w_seg[i];
                    end
                end
                HOLD: begin
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_owner_req) begin
                        // Owner refresh restarts the dwell; the other side keeps waiting.
                        r_state <= GRANT;
                        r_win   <= r_owner;
                        r_a_ack <= (r_owner == REQ_A);
                        r_b_ack <= (r_owner == REQ_B);
                    end else begin
                        r_cnt <= r_cnt - HOLD_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign a_ack           = r_a_ack;
    assign b_ack           = r_b_ack;
    assign owner           = r_owner;
    assign busy            = r_busy;
    assign digit0_segments = r_seg[0];
    assign digit1_segments = r_seg[1];
    assign digit2_segments = r_seg[2];
    assign digit3_segments = r_seg[3];

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Randomized self-checking bench for seg_display_arbiter with a short dwell.
module tb_seg_display_arbiter;

    localparam int unsigned HOLD = 8;
    localparam int unsigned TB_HOLD_W = 4;

    localparam logic [6:0] SEGTAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_req = 1'b0;
    logic [15:0] a_data = '0;
    logic [3:0]  a_blank = '0;
    logic        a_ack;
    logic        b_req = 1'b0;
    logic [15:0] b_data = '0;
    logic [3:0]  b_blank = '0;
    logic        b_ack;
    logic [6:0]  digit0_segments, digit1_segments, digit2_segments, digit3_segments;
    logic        owner;
    logic        busy;

    seg_display_arbiter #(
        .HOLD_W      (TB_HOLD_W),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .a_req           (a_req),
        .a_data          (a_data),
        .a_blank         (a_blank),
        .a_ack           (a_ack),
        .b_req           (b_req),
        .b_data          (b_data),
        .b_blank         (b_blank),
        .b_ack           (b_ack),
        .digit0_segments (digit0_segments),
        .digit1_segments (digit1_segments),
        .digit2_segments (digit2_segments),
        .digit3_segments (digit3_segments),
        .owner           (owner),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   total = 0;
    int   bad = 0;
    int   both_cnt = 0;
    int   long_cnt = 0;
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;
    logic exp_last = 1'b1;

    logic [27:0] obs_frame;
    assign obs_frame = {digit3_segments, digit2_segments, digit1_segments, digit0_segments};

    // Ack protocol monitor: never both at once, never wider than one cycle.
    always @(negedge clk) begin
        if (a_ack && b_ack) both_cnt++;
        if ((a_ack && prev_a) || (b_ack && prev_b)) long_cnt++;
        prev_a = a_ack;
        prev_b = b_ack;
    end

    function automatic logic [27:0] exp_frame(input logic [15:0] d, input logic [3:0] bl);
        logic [27:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*7 +: 7] = bl[i] ? 7'h00 : SEGTAB[d[i*4 +: 4]];
        end
        return r;
    endfunction

    task automatic wait_a(input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (a_ack) begin
                t = cyc;
                a_req = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_b(input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (b_ack) begin
                t = cyc;
                b_req = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int t;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (obs_frame !== 28'h0) begin bad++; $display("FAIL reset_frame: got %h want 0", obs_frame); end
        total++; if ({a_ack, b_ack} !== 2'b00) begin bad++; $display("FAIL reset_acks: got %b want 00", {a_ack, b_ack}); end
        total++; if (owner !== 1'b0) begin bad++; $display("FAIL reset_owner: got %b want 0", owner); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (obs_frame !== 28'h0 || busy !== 1'b0) begin bad++; $display("FAIL reset_release: frame %h busy %b want 0/0", obs_frame, busy); end
        // Reset asserted while an ack is on the wire must kill it at once.
        a_req = 1'b1; a_data = 16'($urandom); a_blank = 4'h0;
        wait_a(4, t);
        rst_n = 1'b0;
        #1;
        total++; if (t < 0 || a_ack !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_in_grant: t %0d ack %b busy %b want ack 0 busy 0", t, a_ack, busy); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_last = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single(input logic [15:0] d, input logic [3:0] bl, input logic who);
        int e, t;
        e = cyc;
        if (who) begin b_req = 1'b1; b_data = d; b_blank = bl; wait_b(6, t); end
        else     begin a_req = 1'b1; a_data = d; a_blank = bl; wait_a(6, t); end
        total++; if (t !== e + 1) begin bad++; $display("FAIL single_ack_cycle: got %0d want %0d", t, e + 1); end
        @(negedge clk);
        total++; if (obs_frame !== exp_frame(d, bl)) begin bad++; $display("FAIL single_frame: got %h want %h", obs_frame, exp_frame(d, bl)); end
        total++; if (owner !== who) begin bad++; $display("FAIL single_owner: got %b want %b", owner, who); end
        repeat (HOLD - 1) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_last_hold_busy: got %b want 1", busy); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy: got %b want 0", busy); end
        exp_last = who;
    endtask

    task automatic test_tie(input logic [15:0] da, input logic [15:0] db);
        int e, ta, tb, tf, ts;
        logic first;
        first = ~exp_last;
        e = cyc;
        a_req = 1'b1; a_data = da; a_blank = 4'h0;
        b_req = 1'b1; b_data = db; b_blank = 4'h0;
        fork
            wait_a(40, ta);
            wait_b(40, tb);
        join
        tf = first ? tb : ta;
        ts = first ? ta : tb;
        total++; if (tf !== e + 1) begin bad++; $display("FAIL tie_first_ack: got %0d want %0d", tf, e + 1); end
        total++; if (ts !== tf + HOLD + 2) begin bad++; $display("FAIL tie_second_ack: got %0d want %0d", ts, tf + HOLD + 2); end
        @(negedge clk);
        total++; if (obs_frame !== exp_frame(first ? da : db, 4'h0)) begin bad++; $display("FAIL tie_frame: got %h want %h", obs_frame, exp_frame(first ? da : db, 4'h0)); end
        total++; if (owner !== ~first) begin bad++; $display("FAIL tie_owner: got %b want %b", owner, ~first); end
        repeat (HOLD) @(negedge clk);
        exp_last = ~first;
    endtask

    task automatic test_rerequest(input int d, input logic [15:0] a2);
        int e, ta1, ta2, tb, exp_ta2, exp_tb, tl;
        logic [15:0] a1, bd;
        logic [3:0]  bbl;
        a1 = 16'($urandom); bd = 16'($urandom); bbl = 4'($urandom);
        e = cyc;
        a_req = 1'b1; a_data = a1; a_blank = 4'h0;
        wait_a(6, ta1);
        total++; if (ta1 !== e + 1) begin bad++; $display("FAIL rereq_first_ack: got %0d want %0d", ta1, e + 1); end
        b_req = 1'b1; b_data = bd; b_blank = bbl;
        repeat (d) @(negedge clk);
        a_req = 1'b1; a_data = a2; a_blank = 4'h0;
        fork
            wait_a(40, ta2);
            wait_b(40, tb);
        join
        if (d <= int'(HOLD) - 1) begin
            exp_ta2 = ta1 + d + 1;
            exp_tb  = exp_ta2 + HOLD + 2;
        end else begin
            exp_tb  = ta1 + HOLD + 2;
            exp_ta2 = exp_tb + HOLD + 2;
        end
        total++; if (ta2 !== exp_ta2) begin bad++; $display("FAIL rereq_owner_ack d=%0d: got %0d want %0d", d, ta2, exp_ta2); end
        total++; if (tb !== exp_tb) begin bad++; $display("FAIL rereq_waiter_ack d=%0d: got %0d want %0d", d, tb, exp_tb); end
        @(negedge clk);
        tl = (ta2 > tb) ? ta2 : tb;
        if (tl == ta2) begin
            total++; if (obs_frame !== exp_frame(a2, 4'h0) || owner !== 1'b0) begin bad++; $display("FAIL rereq_final d=%0d: frame %h owner %b want %h 0", d, obs_frame, owner, exp_frame(a2, 4'h0)); end
            exp_last = 1'b0;
        end else begin
            total++; if (obs_frame !== exp_frame(bd, bbl) || owner !== 1'b1) begin bad++; $display("FAIL rereq_final d=%0d: frame %h owner %b want %h 1", d, obs_frame, owner, exp_frame(bd, bbl)); end
            exp_last = 1'b1;
        end
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic test_blank();
        test_single(16'h8888, 4'b1010, 1'b1);
        total++; if (obs_frame !== {7'h00, 7'h7F, 7'h00, 7'h7F}) begin bad++; $display("FAIL blank_1010: got %h want 007f007f", obs_frame); end
    endtask

    task automatic test_random_writes(input int n);
        for (int i = 0; i < n; i++) begin
            test_single(16'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid_hold();
        int e, t;
        e = cyc;
        b_req = 1'b1; b_data = 16'($urandom); b_blank = 4'h0;
        wait_b(6, t);
        total++; if (t !== e + 1) begin bad++; $display("FAIL midhold_ack: got %0d want %0d", t, e + 1); end
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (obs_frame !== 28'h0) begin bad++; $display("FAIL midhold_frame: got %h want 0", obs_frame); end
        total++; if ({owner, busy, a_ack, b_ack} !== 4'b0000) begin bad++; $display("FAIL midhold_ctrl: got %b want 0000", {owner, busy, a_ack, b_ack}); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_last = 1'b1;
        @(negedge clk);
        test_tie(16'($urandom), 16'hABCD);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single(16'h1234, 4'h0, 1'b0);
        test_tie(16'($urandom), 16'hABCD);
        test_tie(16'($urandom), 16'($urandom));
        test_rerequest(3, 16'h0F0F);
        test_rerequest(1, 16'($urandom));
        test_rerequest(int'(HOLD) - 1, 16'($urandom));
        test_rerequest(int'(HOLD), 16'($urandom));
        test_rerequest(int'($urandom_range(1, HOLD)), 16'($urandom));
        test_blank();
        test_random_writes(6);
        test_reset_mid_hold();
        total++; if (both_cnt !== 0) begin bad++; $display("FAIL ack_overlap: got %0d want 0", both_cnt); end
        total++; if (long_cnt !== 0) begin bad++; $display("FAIL ack_width: got %0d want 0", long_cnt); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
